// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-flow sequencer: flow ops and FSM states.
package pc_seq_pkg;

   localparam logic [2:0] OP_NEXT   = 3'd0;
   localparam logic [2:0] OP_JUMP   = 3'd1;
   localparam logic [2:0] OP_BRANCH = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_RET    = 3'd4;
   localparam logic [2:0] OP_RETI   = 3'd5;
   localparam logic [2:0] OP_HALT   = 3'd6;
   localparam logic [2:0] OP_NEXT7  = 3'd7;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack. Only the occupancy count is reset; entries keep
// stale contents, which is harmless because reads are qualified by depth.
module return_stack #(
   parameter int W     = 7,
   parameter int DEPTH = 4,
   parameter int DW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [DW-1:0] depth_q;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   // Index of the next free slot and of the current top entry.
   always_comb begin
      wr_idx  = AW'(depth_q);
      top_idx = AW'(depth_q - DW'(1));
   end

   // Occupancy counter; push and pop are never requested together.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
      end else if (push && !full) begin
         depth_q <= depth_q + DW'(1);
      end else if (pop && !empty) begin
         depth_q <= depth_q - DW'(1);
      end
   end

   // Entry storage, intentionally without reset.
   always_ff @(posedge clk) begin
      if (push && !full && !reset) begin
         mem[wr_idx] <= din;
      end
   end

   // Status and top-of-stack view.
   always_comb begin
      full  = (depth_q == DW'(DEPTH));
      empty = (depth_q == '0);
      depth = depth_q;
      dout  = empty ? '0 : mem[top_idx];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow unit: registered PC with jump/branch/call/return, a hardware
// return stack, halt, one level-sensitive interrupt and a sticky fault state.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | executing flow ops; irq may be accepted
// ST_HALT  | pc/stack/ie frozen, ops ignored; left only by accepted irq
// ST_FAULT | stack overflow/underflow seen; frozen until reset
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W       = 7,
   parameter int              DEPTH      = 4,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter logic [PC_W-1:0] IRQ_VECTOR = 7'h70
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic [2:0]                 op,
   input  logic                       cond,
   input  logic [PC_W-1:0]            target,
   input  logic                       irq,
   output logic                       irq_ack,
   output logic [PC_W-1:0]            pc,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       ie,
   output logic                       halted,
   output logic                       fault
);

   localparam int DW = $clog2(DEPTH + 1);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc;
   logic            ie_q, ie_d;
   logic            push, pop, accept;
   logic [PC_W-1:0] push_data, stk_dout;
   logic            stk_full, stk_empty;
   logic [DW-1:0]   stk_depth;

   return_stack #(
      .W     (PC_W),
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push && !reset),
      .pop   (pop && !reset),
      .din   (push_data),
      .dout  (stk_dout),
      .depth (stk_depth),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Interrupt arbitration: accepted only with room to save the resume address.
   always_comb begin
      pc_inc = pc_q + PC_W'(1);
      accept = irq && ie_q && !stall && !reset && !stk_full &&
               (state_q == ST_RUN || state_q == ST_HALT);
   end

   // Next-state, next-pc and stack control; an accepted irq discards op.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ie_d      = ie_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = pc_inc;
      if (accept) begin
         push      = 1'b1;
         push_data = pc_q;
         pc_d      = IRQ_VECTOR;
         ie_d      = 1'b0;
         state_d   = ST_RUN;
      end else if (!stall && state_q == ST_RUN) begin
         case (op)
            OP_JUMP:   pc_d = target;
            OP_BRANCH: pc_d = cond ? target : pc_inc;
            OP_CALL: begin
               if (stk_full) begin
                  state_d = ST_FAULT;
               end else begin
                  push = 1'b1;
                  pc_d = target;
               end
            end
            OP_RET, OP_RETI: begin
               if (stk_empty) begin
                  state_d = ST_FAULT;
               end else begin
                  pop  = 1'b1;
                  pc_d = stk_dout;
                  if (op == OP_RETI) ie_d = 1'b1;
               end
            end
            OP_HALT: begin
               pc_d    = pc_inc;
               state_d = ST_HALT;
            end
            OP_NEXT, OP_NEXT7: pc_d = pc_inc;
            default:           pc_d = pc_inc;
         endcase
      end
   end

   // State, pc and interrupt-enable registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         ie_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ie_q    <= ie_d;
      end
   end

   // Output view.
   always_comb begin
      irq_ack = accept;
      pc      = pc_q;
      depth   = stk_depth;
      ie      = ie_q;
      halted  = (state_q == ST_HALT);
      fault   = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset, stall, cond, irq;
   logic [2:0] op;
   logic [6:0] target;
   logic       irq_ack, ie, halted, fault;
   logic [6:0] pc;
   logic [2:0] depth;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BRA = 3'd2, CAL = 3'd3,
                          RET = 3'd4, RTI = 3'd5, HLT = 3'd6;

   pc_sequencer #(
      .PC_W       (7),
      .DEPTH      (4),
      .RESET_PC   (7'h00),
      .IRQ_VECTOR (7'h70)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .op      (op),
      .cond    (cond),
      .target  (target),
      .irq     (irq),
      .irq_ack (irq_ack),
      .pc      (pc),
      .depth   (depth),
      .ie      (ie),
      .halted  (halted),
      .fault   (fault)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [6:0] t, input logic c,
                        input logic s, input logic i);
      op = o; target = t; cond = c; stall = s; irq = i;
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      drive(JMP, 7'h22, 1'b0, 1'b0, 1'b0);
      tick();
      drive(CAL, 7'h33, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (depth !== 3'd1) $display("FAIL rst_pre depth=%0d exp=1", depth); else n_pass++;
      reset = 1'b1;
      drive(CAL, 7'h44, 1'b1, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL rst_ack irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      reset = 1'b0;
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++; if (pc !== 7'h00) $display("FAIL rst_pc pc=%h exp=00", pc); else n_pass++;
      n_total++; if (depth !== 3'd0) $display("FAIL rst_depth depth=%0d exp=0", depth); else n_pass++;
      n_total++; if (ie !== 1'b1) $display("FAIL rst_ie ie=%b exp=1", ie); else n_pass++;
      n_total++; if (halted !== 1'b0 || fault !== 1'b0)
         $display("FAIL rst_state halted=%b fault=%b exp=0,0", halted, fault); else n_pass++;
   endtask

   task automatic test_next;
      logic [6:0] exp_pc;
      do_reset();
      n_total++; if (pc !== 7'h00) $display("FAIL next0 pc=%h exp=00", pc); else n_pass++;
      for (int k = 1; k <= 3; k++) begin
         drive(NXT, 7'h00, 1'b0, 1'b0, 1'b0);
         tick();
         exp_pc = 7'(k);
         n_total++; if (pc !== exp_pc) $display("FAIL next%0d pc=%h exp=%h", k, pc, exp_pc); else n_pass++;
      end
      drive(JMP, 7'h7f, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h7f) $display("FAIL jump127 pc=%h exp=7f", pc); else n_pass++;
      drive(3'd7, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h00) $display("FAIL wrap pc=%h exp=00", pc); else n_pass++;
   endtask

   task automatic test_branch;
      drive(JMP, 7'h05, 1'b0, 1'b0, 1'b0);
      tick();
      drive(BRA, 7'h20, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h06) $display("FAIL br_nt pc=%h exp=06", pc); else n_pass++;
      drive(BRA, 7'h20, 1'b1, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h20) $display("FAIL br_t pc=%h exp=20", pc); else n_pass++;
      drive(JMP, 7'h40, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      n_total++; if (pc !== 7'h20) $display("FAIL stall pc=%h exp=20", pc); else n_pass++;
      drive(JMP, 7'h40, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h40) $display("FAIL unstall pc=%h exp=40", pc); else n_pass++;
   endtask

   task automatic test_calls;
      logic [6:0] ret_exp [4];
      ret_exp[0] = 7'h31; ret_exp[1] = 7'h21; ret_exp[2] = 7'h11; ret_exp[3] = 7'h01;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(CAL, 7'(k * 16), 1'b0, 1'b0, 1'b0);
         tick();
         n_total++; if (depth !== 3'(k) || pc !== 7'(k * 16))
            $display("FAIL call%0d depth=%0d pc=%h exp=%0d,%h", k, depth, pc, k, 7'(k * 16)); else n_pass++;
      end
      for (int k = 0; k < 4; k++) begin
         drive(RET, 7'h00, 1'b0, 1'b0, 1'b0);
         tick();
         n_total++; if (pc !== ret_exp[k] || depth !== 3'(3 - k))
            $display("FAIL ret%0d pc=%h depth=%0d exp=%h,%0d", k, pc, depth, ret_exp[k], 3 - k); else n_pass++;
      end
      for (int k = 1; k <= 4; k++) begin
         drive(CAL, 7'(k * 16), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(CAL, 7'h50, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (fault !== 1'b1 || pc !== 7'h40 || depth !== 3'd4)
         $display("FAIL ovf fault=%b pc=%h depth=%0d exp=1,40,4", fault, pc, depth); else n_pass++;
      drive(RET, 7'h00, 1'b0, 1'b0, 1'b1);
      tick();
      n_total++; if (fault !== 1'b1 || pc !== 7'h40 || depth !== 3'd4)
         $display("FAIL ovf_frozen fault=%b pc=%h depth=%0d exp=1,40,4", fault, pc, depth); else n_pass++;
      do_reset();
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      drive(RET, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (fault !== 1'b1 || pc !== 7'h02)
         $display("FAIL udf fault=%b pc=%h exp=1,02", fault, pc); else n_pass++;
      drive(JMP, 7'h30, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL fault_irq irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h02 || depth !== 3'd0 || ie !== 1'b1)
         $display("FAIL fault_frozen pc=%h depth=%0d ie=%b exp=02,0,1", pc, depth, ie); else n_pass++;
      do_reset();
      n_total++; if (fault !== 1'b0 || pc !== 7'h00 || depth !== 3'd0)
         $display("FAIL fault_clr fault=%b pc=%h depth=%0d exp=0,00,0", fault, pc, depth); else n_pass++;
   endtask

   task automatic test_irq;
      do_reset();
      drive(JMP, 7'h10, 1'b0, 1'b0, 1'b0);
      tick();
      drive(JMP, 7'h30, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b1) $display("FAIL irq_ack irq_ack=%b exp=1", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h70 || ie !== 1'b0 || depth !== 3'd1)
         $display("FAIL irq_entry pc=%h ie=%b depth=%0d exp=70,0,1", pc, ie, depth); else n_pass++;
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL irq_held irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h71) $display("FAIL handler pc=%h exp=71", pc); else n_pass++;
      drive(RTI, 7'h00, 1'b0, 1'b0, 1'b1);
      tick();
      n_total++; if (pc !== 7'h10 || ie !== 1'b1 || depth !== 3'd0)
         $display("FAIL reti pc=%h ie=%b depth=%0d exp=10,1,0", pc, ie, depth); else n_pass++;
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b1) $display("FAIL reaccept irq_ack=%b exp=1", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h70 || depth !== 3'd1)
         $display("FAIL reentry pc=%h depth=%0d exp=70,1", pc, depth); else n_pass++;
      drive(RTI, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      drive(NXT, 7'h00, 1'b0, 1'b1, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL stall_irq irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h10 || ie !== 1'b1 || depth !== 3'd0)
         $display("FAIL stall_frozen pc=%h ie=%b depth=%0d exp=10,1,0", pc, ie, depth); else n_pass++;
   endtask

   task automatic test_halt;
      do_reset();
      drive(JMP, 7'h03, 1'b0, 1'b0, 1'b0);
      tick();
      drive(HLT, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h04 || halted !== 1'b1)
         $display("FAIL halt pc=%h halted=%b exp=04,1", pc, halted); else n_pass++;
      drive(JMP, 7'h50, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h04 || halted !== 1'b1)
         $display("FAIL halt_ign pc=%h halted=%b exp=04,1", pc, halted); else n_pass++;
      drive(JMP, 7'h50, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b1) $display("FAIL halt_ack irq_ack=%b exp=1", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h70 || halted !== 1'b0 || depth !== 3'd1)
         $display("FAIL wake pc=%h halted=%b depth=%0d exp=70,0,1", pc, halted, depth); else n_pass++;
      drive(RTI, 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (pc !== 7'h04 || ie !== 1'b1)
         $display("FAIL halt_reti pc=%h ie=%b exp=04,1", pc, ie); else n_pass++;
      do_reset();
      drive(CAL, 7'h10, 1'b0, 1'b0, 1'b0); tick();
      drive(CAL, 7'h20, 1'b0, 1'b0, 1'b0); tick();
      drive(CAL, 7'h30, 1'b0, 1'b0, 1'b0); tick();
      drive(CAL, 7'h03, 1'b0, 1'b0, 1'b0); tick();
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL full_ack irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      n_total++; if (pc !== 7'h04 || fault !== 1'b0 || depth !== 3'd4)
         $display("FAIL full_run pc=%h fault=%b depth=%0d exp=04,0,4", pc, fault, depth); else n_pass++;
      drive(HLT, 7'h00, 1'b0, 1'b0, 1'b1);
      tick();
      drive(NXT, 7'h00, 1'b0, 1'b0, 1'b1);
      n_total++; if (irq_ack !== 1'b0) $display("FAIL full_halt_ack irq_ack=%b exp=0", irq_ack); else n_pass++;
      tick();
      n_total++; if (halted !== 1'b1 || pc !== 7'h05 || depth !== 3'd4)
         $display("FAIL full_halt halted=%b pc=%h depth=%0d exp=1,05,4", halted, pc, depth); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      op = 3'd0; target = 7'h00; cond = 1'b0; stall = 1'b0; irq = 1'b0;
      test_reset();
      test_next();
      test_branch();
      test_calls();
      test_irq();
      test_halt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
